// File: rtl/asynchronous_fifo.sv
// Purpose     : single-clock FIFO, DEPTH x WIDTH register array addressed by wrap-bit pointers.
// Latency     : write visible to the read side one edge after acceptance; read data registered (1 edge).
// Backpressure: writes dropped while full, reads dropped while empty; full/empty are the flow-control status.
//
// Ports:
//   w_clk     single clock for both sides; all state changes on its rising edge
//   w_rst     asynchronous active-low reset (assert immediately, release on next edge)
//   w_en      write request, accepted when !full
//   r_en      read request, accepted when !empty
//   data_in   write data, captured on an accepted write
//   data_out  registered read data; holds its value when no read is accepted
//   full      DEPTH entries stored
//   empty     no entries stored
//
// Optional build macro FIFO_ERR_FLAGS_EN adds two sticky error outputs:
//   overflow  set by any edge with w_en while full
//   underflow set by any edge with r_en while empty
// Both clear only on w_rst and never influence data or pointers.

module asynchronous_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             w_clk,
    input  logic             w_rst,
    input  logic             w_en,
    input  logic             r_en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);

    // DEPTH must be a power of two and >= 2, so AW >= 1 and the
    // low-address slice below is always well formed.
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit: equal pointers mean empty,
    // equal addresses with differing wrap bits mean full.
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];

    logic write_ok;
    logic read_ok;

    // Flags decode straight from the registered pointers, so they reflect
    // an update in the same cycle and follow reset asynchronously.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    // Acceptance uses pre-edge flags. At empty a simultaneous read is
    // rejected (no bypass of data_in); at full a simultaneous write is.
    assign write_ok = w_en && !full;
    assign read_ok  = r_en && !empty;

    // Storage is deliberately not reset; stale entries are unreachable
    // because reset also equalises the pointers.
    always_ff @(posedge w_clk) begin
        if (write_ok) begin
            mem[wptr[AW-1:0]] <= data_in;
        end
    end

    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            wptr <= '0;
        end else if (write_ok) begin
            wptr <= wptr + PTR_ONE;
        end
    end

    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            rptr     <= '0;
            data_out <= '0;
        end else if (read_ok) begin
            data_out <= mem[rptr[AW-1:0]];
            rptr     <= rptr + PTR_ONE;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_en && full) begin
                overflow <= 1'b1;
            end
            if (r_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_asynchronous_fifo.sv
// Purpose     : directed self-checking bench for asynchronous_fifo (DEPTH=8, WIDTH=8).
// Latency     : inputs driven at the falling edge, outputs sampled 1 ns after the rising edge.
// Backpressure: exercises writes at full and reads at empty; error flags checked when FIFO_ERR_FLAGS_EN is set.

module tb_asynchronous_fifo;

    logic       w_clk;
    logic       w_rst;
    logic       w_en;
    logic       r_en;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
`ifdef FIFO_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    int total = 0;
    int bad   = 0;

    asynchronous_fifo #(
        .DEPTH (8),
        .WIDTH (8)
    ) u_dut (
        .w_clk    (w_clk),
        .w_rst    (w_rst),
        .w_en     (w_en),
        .r_en     (r_en),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .overflow (overflow),
        .underflow(underflow)
`endif
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive at the falling edge, return 1 ns after
    // the following rising edge with requests dropped again.
    task automatic step(input logic we, input logic re, input logic [7:0] d);
        @(negedge w_clk);
        w_en    = we;
        r_en    = re;
        data_in = d;
        @(posedge w_clk);
        #1;
        w_en = 1'b0;
        r_en = 1'b0;
    endtask

    initial begin
        w_rst   = 1'b0;
        w_en    = 1'b0;
        r_en    = 1'b0;
        data_in = 8'h00;

        // Reset state
        #20;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_dout", data_out, 0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
`endif
        @(negedge w_clk);
        w_rst = 1'b1;

        // Fill 0x01..0x08
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 8'(i));
            chk("fill_empty", empty, 0);
            chk("fill_full", full, (i == 8) ? 1 : 0);
        end
`ifdef FIFO_ERR_FLAGS_EN
        chk("fill_ovf_clear", overflow, 0);
`endif
        // Write at full is dropped
        step(1'b1, 1'b0, 8'hFF);
        chk("ovr_full", full, 1);
        chk("ovr_dout", data_out, 0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("ovr_ovf", overflow, 1);
`endif

        // Drain, in order, one per edge
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk("drain_dout", data_out, i);
            chk("drain_full", full, 0);
            chk("drain_empty", empty, (i == 8) ? 1 : 0);
        end
`ifdef FIFO_ERR_FLAGS_EN
        chk("drain_unf_clear", underflow, 0);
`endif
        // Read at empty holds data_out
        step(1'b0, 1'b1, 8'h00);
        chk("unr_dout", data_out, 8'h08);
        chk("unr_empty", empty, 1);
`ifdef FIFO_ERR_FLAGS_EN
        chk("unr_unf", underflow, 1);
`endif

        // Simultaneous at empty: only the write happens, no bypass
        step(1'b1, 1'b1, 8'h10);
        chk("sim0_empty", empty, 0);
        chk("sim0_dout", data_out, 8'h08);
        step(1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b0, 8'h12);

        // Three stored: five write+read edges keep occupancy at three
        begin
            logic [7:0] exp_rd [5];
            exp_rd[0] = 8'h10; exp_rd[1] = 8'h11; exp_rd[2] = 8'h12;
            exp_rd[3] = 8'h20; exp_rd[4] = 8'h21;
            for (int i = 0; i < 5; i++) begin
                step(1'b1, 1'b1, 8'(8'h20 + i));
                chk("sim_dout", data_out, exp_rd[i]);
                chk("sim_empty", empty, 0);
                chk("sim_full", full, 0);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk("sim_tail", data_out, 8'h22 + i);
        end
        chk("sim_tail_empty", empty, 1);

        // Wrap: write 6, read 6, write 8, read 8
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk("wrap_rd6", data_out, 8'h30 + i);
        end
        chk("wrap_mid_empty", empty, 1);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 8'(8'h40 + i));
            chk("wrap_full", full, (i == 7) ? 1 : 0);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk("wrap_rd8", data_out, 8'h40 + i);
        end
        chk("wrap_end_empty", empty, 1);

        // Mid-operation asynchronous reset with five stored
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h50 + i));
        chk("pre_rst_empty", empty, 0);
        @(negedge w_clk);
        #2 w_rst = 1'b0;
        #1;
        chk("arst_empty", empty, 1);
        chk("arst_full", full, 0);
        chk("arst_dout", data_out, 0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("arst_ovf", overflow, 0);
        chk("arst_unf", underflow, 0);
`endif
        @(negedge w_clk);
        w_rst = 1'b1;
        step(1'b1, 1'b0, 8'hA5);
        chk("post_wr_empty", empty, 0);
        step(1'b0, 1'b1, 8'h00);
        chk("post_rd_dout", data_out, 8'hA5);
        chk("post_rd_empty", empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/asynchronous_fifo.md
Name: asynchronous_fifo

Overview:
- Parameterised first-in/first-out buffer between a producer and a consumer.
- Both sides run from a single clock.
- Storage is a DEPTH x WIDTH register array addressed by write and read pointers.
- Provides full/empty status and a registered read-data output. Used as the shared buffering primitive on data paths.

Parameters:
- DEPTH, 8: number of entries. Must be a power of 2 and at least 2. Pointer address width AW = log2(DEPTH).
- WIDTH, 8: data word width in bits.

Ports:
- w_clk  input  1  single clock for both write and read sides; all state changes on its rising edge.
- w_rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- w_en  input  1  write request; sampled on rising w_clk.
- r_en  input  1  read request; sampled on rising w_clk.
- data_in  input  WIDTH  write data, captured when a write is accepted.
- data_out  output  WIDTH  read data; registered.
- full  output  1  high when DEPTH entries are stored.
- empty  output  1  high when 0 entries are stored.

Behaviour:
- Interface: one clock, w_clk. Reset w_rst is asynchronous and active-low.
- Reset (w_rst=0, takes effect immediately, independent of the clock):
  - wptr=0, rptr=0, data_out=0, empty=1, full=0.
  - Memory contents are not reset.
  - Release is synchronous to the next rising edge; w_rst is deasserted away from the edge.
- Pointers:
  - wptr and rptr are AW+1 bits wide. The low AW bits address memory; the MSB is a wrap bit.
  - Pointers increment modulo 2^(AW+1), so wrap-around is natural.
- Flags:
  - Decoded combinationally from the registered pointers, so they settle in the same cycle the pointers update.
  - empty = (wptr == rptr).
  - full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]).
- Write acceptance:
  - write_ok = w_en && !full, with full taken from its pre-edge value.
  - On acceptance: mem[wptr[AW-1:0]] <= data_in and wptr <= wptr+1.
  - A write while full is ignored: no pointer change, no memory change.
- Read acceptance:
  - read_ok = r_en && !empty, with empty taken from its pre-edge value.
  - On acceptance: data_out <= mem[rptr[AW-1:0]] and rptr <= rptr+1.
  - Latency: data is valid on data_out after the rising edge that accepts the read.
  - A read while empty is ignored; data_out holds its last value.
- data_out holds its value whenever no read is accepted.
- Simultaneous w_en and r_en:
  - Neither full nor empty: both are accepted in the same edge and occupancy is unchanged.
  - When empty: only the write occurs. The read is rejected and data_out does not bypass data_in.
  - When full: only the read occurs; the write is rejected.
- Ordering: strict FIFO; no data loss or duplication across any number of wraps.
- Reset mid-operation: all queued data is discarded. Flags return to empty=1, full=0 immediately on w_rst assertion.
- Undriven or X on w_en/r_en outside reset is illegal stimulus.

Optional Feature:
- Macro FIFO_ERR_FLAGS_EN.
- When defined, two extra outputs are added:
  - overflow (1 bit): sticky, set on any edge with w_en=1 && full=1.
  - underflow (1 bit): sticky, set on any edge with r_en=1 && empty=1.
  - Both are cleared only by w_rst (reset value 0) and never affect data or pointers.
- When not defined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold w_rst=0 for 20 ns with w_en=r_en=0 -> empty=1, full=0, data_out=0; asynchronous assertion mid-cycle clears the flags immediately.
- Fill: write 0x01..0x08 on 8 consecutive edges -> full=1 after the 8th edge, empty=0 after the 1st. A 9th write of 0xFF is ignored (overflow=1 if FIFO_ERR_FLAGS_EN).
- Drain: 8 consecutive reads -> data_out 0x01..0x08 in order, one per edge. empty=1 after the 8th; a further read holds data_out=0x08 (underflow=1 if enabled).
- Simultaneous: with 3 entries stored, assert w_en and r_en for 5 edges -> occupancy stays 3 and output order is preserved. At empty, a simultaneous w_en/r_en yields only the write (empty=0, data_out unchanged).
- Wrap: write 6, read 6, then write 8 -> full=1 with pointers wrapped; reading 8 returns the last 8 writes in order.
- Mid-operation reset: with 5 entries stored, pulse w_rst=0 -> empty=1, full=0, data_out=0. The subsequent write/read of 0xA5 returns 0xA5.
